// File: rtl/fifo_burst_reader_pkg.sv
// Shared types for the FIFO burst reader: FSM state encoding and skid depth.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Output stream of the burst reader: valid/ready with a per-burst last marker.
interface fifo_burst_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/fifo_burst_reader_skid.sv
// Two-entry in-order buffer between the FIFO read port and the output stream.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_ready,
  output logic         head_valid,
  output logic [W-1:0] head_data,
  output logic [1:0]   occ
);

  logic [W-1:0] tail_q;
  logic [1:0]   cnt_q;
  logic         pop;

  assign pop        = (cnt_q != 2'd0) && pop_ready;
  assign head_valid = (cnt_q != 2'd0);
  assign occ        = cnt_q;

  // Head is the registered output; the tail only holds the second entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_data <= '0;
      tail_q    <= '0;
      cnt_q     <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_data <= push_data;
          else               tail_q    <= push_data;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          head_data <= tail_q;
          cnt_q     <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) head_data <= push_data;
          else begin
            head_data <= tail_q;
            tail_q    <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && cnt_q == 2'(SKID_DEPTH)));

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side master for sync_fifo: pulls bursts through the registered read port
// and presents them on a valid/ready stream with m_last on each burst's final word.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_valid_rd,
  input  logic                  fifo_empty,
  input  logic [ADDR_WIDTH:0]   fifo_count,
  input  logic                  flush,
  fifo_burst_reader_if.master   m,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH:0] BLEN = (ADDR_WIDTH+1)'(BURST_LEN);
  localparam logic [ADDR_WIDTH:0] ONE  = (ADDR_WIDTH+1)'(1);

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH:0]   burst_len_q, issued_q, returned_q, load_len;
  logic                  in_flight_q, load, xfer, push_last;
  logic [1:0]            occ, pending;
  logic                  head_valid;
  logic [DATA_WIDTH:0]   head_data;

  fifo_skid_buf #(.W(DATA_WIDTH + 1)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_valid_rd),
    .push_data ({push_last, fifo_rd_data}),
    .pop_ready (m.m_ready),
    .head_valid(head_valid),
    .head_data (head_data),
    .occ       (occ)
  );

  assign m.m_valid = head_valid;
  assign {m.m_last, m.m_data} = head_data;
  assign xfer      = head_valid & m.m_ready;
  assign busy      = (state_q != IDLE);
  assign push_last = (returned_q + ONE == burst_len_q);

  // Credit ignores a pop happening this cycle so the skid can never overflow.
  assign pending    = occ + {1'b0, in_flight_q};
  assign fifo_rd_en = (state_q == READ) && (issued_q < burst_len_q) &&
                      !fifo_empty && (pending < 2'd2);

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_len = '0;
    case (state_q)
      IDLE: begin
        if (fifo_count >= BLEN) begin
          state_d  = READ;
          load     = 1'b1;
          load_len = BLEN;
        end else if (flush && fifo_count != '0) begin
          state_d  = READ;
          load     = 1'b1;
          load_len = fifo_count;
        end
      end
      READ:    if (issued_q == burst_len_q) state_d = DRAIN;
      DRAIN:   if (returned_q == burst_len_q && xfer && m.m_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      burst_len_q <= '0;
      issued_q    <= '0;
      returned_q  <= '0;
      in_flight_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_flight_q <= fifo_rd_en;
      if (load) begin
        burst_len_q <= load_len;
        issued_q    <= '0;
        returned_q  <= '0;
      end else begin
        if (fifo_rd_en)    issued_q   <= issued_q + ONE;
        if (fifo_valid_rd) returned_q <= returned_q + ONE;
      end
    end
  end

endmodule
